// File: rtl/bcd_operand_entry.sv
// Keypad front end: collects two BCD operands and an operator, pulses calc_valid on '='.
// Optional feature: define BACKSPACE_EN to build backspace handling with count restore.
module bcd_operand_entry #(
    parameter int         DIGITS  = 3,
    parameter logic [3:0] KEY_ADD = 4'hA,
    parameter logic [3:0] KEY_SUB = 4'hB,
    parameter logic [3:0] KEY_EQ  = 4'hC,
    parameter logic [3:0] KEY_CLR = 4'hD,
    parameter logic [3:0] KEY_BS  = 4'hE
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                key_valid,
    input  logic [3:0]          key_code,
    output logic [3:0]          op_sign,
    output logic [4*DIGITS-1:0] num,
    output logic [4*DIGITS-1:0] sub,
    output logic                calc_valid,
    output logic [15:0]         entry_disp,
    output logic [1:0]          state_o
);
    localparam int OW = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);
    localparam logic [3:0] SIGN_ADD = 4'd10;
    localparam logic [3:0] SIGN_SUB = 4'd0;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIGITS);

    typedef enum logic [1:0] {
        ENTER_A = 2'd0,
        ENTER_B = 2'd1,
        DONE    = 2'd2,
        ILLEGAL = 2'd3
    } state_t;

    state_t        state, state_nx;
    logic [OW-1:0] num_nx, sub_nx;
    logic [3:0]    op_sign_nx;
    logic          calc_nx;
    logic [15:0]   disp_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          is_digit, is_op;

`ifdef BACKSPACE_EN
    // Digit count of num, saved when the operator moves entry to sub.
    logic [CW-1:0] a_cnt, a_cnt_nx;
`endif

    assign is_digit = (key_code <= 4'd9);
    assign is_op    = (key_code == KEY_ADD) || (key_code == KEY_SUB);

    always_comb begin
        state_nx   = state;
        num_nx     = num;
        sub_nx     = sub;
        op_sign_nx = op_sign;
        cnt_nx     = cnt;
        calc_nx    = 1'b0;
`ifdef BACKSPACE_EN
        a_cnt_nx   = a_cnt;
`endif
        if (state == ILLEGAL || (key_valid && key_code == KEY_CLR)) begin
            state_nx   = ENTER_A;
            num_nx     = '0;
            sub_nx     = '0;
            op_sign_nx = SIGN_ADD;
            cnt_nx     = '0;
`ifdef BACKSPACE_EN
            a_cnt_nx   = '0;
`endif
        end else if (key_valid) begin
            case (state)
                ENTER_A: begin
                    if (is_digit) begin
                        if (cnt < CNT_MAX) begin
                            num_nx = {num[OW-5:0], key_code};
                            cnt_nx = cnt + 1'b1;
                        end
                    end else if (is_op) begin
                        op_sign_nx = (key_code == KEY_ADD) ? SIGN_ADD : SIGN_SUB;
                        sub_nx     = '0;
                        cnt_nx     = '0;
                        state_nx   = ENTER_B;
`ifdef BACKSPACE_EN
                        a_cnt_nx   = cnt;
`endif
                    end
`ifdef BACKSPACE_EN
                    else if (key_code == KEY_BS && cnt != '0) begin
                        num_nx = {4'd0, num[OW-1:4]};
                        cnt_nx = cnt - 1'b1;
                    end
`endif
                end
                ENTER_B: begin
                    if (is_digit) begin
                        if (cnt < CNT_MAX) begin
                            sub_nx = {sub[OW-5:0], key_code};
                            cnt_nx = cnt + 1'b1;
                        end
                    end else if (is_op) begin
                        op_sign_nx = (key_code == KEY_ADD) ? SIGN_ADD : SIGN_SUB;
                    end else if (key_code == KEY_EQ) begin
                        calc_nx  = 1'b1;
                        state_nx = DONE;
                    end
`ifdef BACKSPACE_EN
                    else if (key_code == KEY_BS) begin
                        if (cnt != '0) begin
                            sub_nx = {4'd0, sub[OW-1:4]};
                            cnt_nx = cnt - 1'b1;
                        end else begin
                            state_nx = ENTER_A;
                            cnt_nx   = a_cnt;
                        end
                    end
`endif
                end
                DONE: begin
                    // A digit after a result starts a fresh calculation.
                    if (is_digit) begin
                        num_nx     = {{(OW-4){1'b0}}, key_code};
                        sub_nx     = '0;
                        op_sign_nx = SIGN_ADD;
                        cnt_nx     = CW'(1);
                        state_nx   = ENTER_A;
                    end
                end
                default: ;
            endcase
        end
        disp_nx = (state_nx == ENTER_A) ? {4'd0, num_nx} : {op_sign_nx, sub_nx};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ENTER_A;
            num        <= '0;
            sub        <= '0;
            op_sign    <= SIGN_ADD;
            cnt        <= '0;
            calc_valid <= 1'b0;
            entry_disp <= '0;
        end else begin
            state      <= state_nx;
            num        <= num_nx;
            sub        <= sub_nx;
            op_sign    <= op_sign_nx;
            cnt        <= cnt_nx;
            calc_valid <= calc_nx;
            entry_disp <= disp_nx;
        end
    end

`ifdef BACKSPACE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) a_cnt <= '0;
        else        a_cnt <= a_cnt_nx;
    end
`endif

    assign state_o = state;

endmodule

// File: tb/tb_bcd_operand_entry.sv
// Directed-vector bench for bcd_operand_entry (default build, BACKSPACE_EN undefined).
module tb_bcd_operand_entry;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'h0;
    logic [3:0]  op_sign;
    logic [11:0] num, sub;
    logic        calc_valid;
    logic [15:0] entry_disp;
    logic [1:0]  state_o;

    int total = 0;
    int bad = 0;
    int pulses = 0;

    localparam logic [3:0] K_ADD = 4'hA, K_SUB = 4'hB, K_EQ = 4'hC, K_CLR = 4'hD, K_BS = 4'hE;

    bcd_operand_entry dut (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
        .op_sign(op_sign), .num(num), .sub(sub), .calc_valid(calc_valid),
        .entry_disp(entry_disp), .state_o(state_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (calc_valid === 1'b1) pulses++;

    task automatic press(input logic [3:0] k);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = k;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
        if (state_o !== 2'd0) begin bad++; $display("FAIL rst_state got=%0d want=0", state_o); end total++;
        if (num !== 12'h000 || sub !== 12'h000) begin bad++; $display("FAIL rst_operands got num=%h sub=%h want 000/000", num, sub); end total++;
        if (op_sign !== 4'd10) begin bad++; $display("FAIL rst_op_sign got=%0d want=10", op_sign); end total++;
        if (calc_valid !== 1'b0 || entry_disp !== 16'h0000) begin bad++; $display("FAIL rst_outputs got calc=%b disp=%h want 0/0000", calc_valid, entry_disp); end total++;
    endtask

    task automatic test_subtract;
        int p0;
        press(4'd1); press(4'd2); press(4'd3);
        if (entry_disp !== 16'h0123) begin bad++; $display("FAIL sub_disp_a got=%h want=0123", entry_disp); end total++;
        press(K_SUB);
        if (state_o !== 2'd1 || entry_disp !== 16'h0000) begin bad++; $display("FAIL sub_enter_b got state=%0d disp=%h want 1/0000", state_o, entry_disp); end total++;
        press(4'd4); press(4'd5);
        if (entry_disp !== 16'h0045) begin bad++; $display("FAIL sub_disp_b got=%h want=0045", entry_disp); end total++;
        p0 = pulses;
        press(K_EQ);
        if (calc_valid !== 1'b1 || state_o !== 2'd2) begin bad++; $display("FAIL sub_eq got calc=%b state=%0d want 1/2", calc_valid, state_o); end total++;
        if (num !== 12'h123 || sub !== 12'h045 || op_sign !== 4'd0) begin bad++; $display("FAIL sub_result got %h %h %0d want 123 045 0", num, sub, op_sign); end total++;
        idle(2);
        if (calc_valid !== 1'b0 || pulses - p0 !== 1) begin bad++; $display("FAIL sub_pulse got calc=%b pulses=%0d want 0/1", calc_valid, pulses - p0); end total++;
        if (entry_disp !== 16'h0045) begin bad++; $display("FAIL sub_disp_done got=%h want=0045", entry_disp); end total++;
    endtask

    task automatic test_overflow;
        int p0;
        press(K_CLR);
        press(4'd9); press(4'd9); press(4'd9); press(4'd9);
        if (num !== 12'h999) begin bad++; $display("FAIL ovf_num got=%h want=999", num); end total++;
        press(K_ADD);
        if (entry_disp !== 16'hA000) begin bad++; $display("FAIL ovf_disp_op got=%h want=A000", entry_disp); end total++;
        press(4'd7);
        p0 = pulses;
        press(K_EQ);
        idle(1);
        if (num !== 12'h999 || sub !== 12'h007 || op_sign !== 4'd10) begin bad++; $display("FAIL ovf_result got %h %h %0d want 999 007 10", num, sub, op_sign); end total++;
        press(K_EQ); press(K_SUB);
        idle(2);
        if (pulses - p0 !== 1 || op_sign !== 4'd10 || state_o !== 2'd2) begin bad++; $display("FAIL done_ignore got pulses=%0d op=%0d state=%0d want 1/10/2", pulses - p0, op_sign, state_o); end total++;
    endtask

    task automatic test_last_op;
        press(K_CLR);
        press(4'd5); press(K_ADD); press(K_SUB); press(4'd2); press(K_EQ);
        if (op_sign !== 4'd0 || num !== 12'h005 || sub !== 12'h002) begin bad++; $display("FAIL lastop got op=%0d num=%h sub=%h want 0 005 002", op_sign, num, sub); end total++;
    endtask

    task automatic test_done_digit;
        int p0;
        press(4'd8);
        if (num !== 12'h008 || sub !== 12'h000 || state_o !== 2'd0) begin bad++; $display("FAIL done_digit got num=%h sub=%h state=%0d want 008 000 0", num, sub, state_o); end total++;
        if (op_sign !== 4'd10 || entry_disp !== 16'h0008) begin bad++; $display("FAIL done_digit_disp got op=%0d disp=%h want 10 0008", op_sign, entry_disp); end total++;
        p0 = pulses;
        press(K_EQ);
        idle(2);
        if (pulses - p0 !== 0 || state_o !== 2'd0) begin bad++; $display("FAIL eq_in_a got pulses=%0d state=%0d want 0/0", pulses - p0, state_o); end total++;
    endtask

    task automatic test_ignored;
        press(K_CLR);
        press(4'd1); press(4'd2);
        press(4'hF);
        press(K_BS);
        if (num !== 12'h012 || state_o !== 2'd0) begin bad++; $display("FAIL unused_codes got num=%h state=%0d want 012/0", num, state_o); end total++;
        @(negedge clk);
        key_code = 4'd7;
        idle(3);
        if (num !== 12'h012 || entry_disp !== 16'h0012) begin bad++; $display("FAIL hold got num=%h disp=%h want 012/0012", num, entry_disp); end total++;
        press(4'd3); press(4'd4);
        if (num !== 12'h123) begin bad++; $display("FAIL full_b4 got num=%h want=123", num); end total++;
    endtask

    task automatic test_empty_operands;
        int p0;
        press(K_CLR);
        p0 = pulses;
        press(K_ADD); press(K_EQ);
        idle(2);
        if (num !== 12'h000 || sub !== 12'h000 || pulses - p0 !== 1 || state_o !== 2'd2) begin bad++; $display("FAIL empty got num=%h sub=%h pulses=%0d state=%0d want 000 000 1 2", num, sub, pulses - p0, state_o); end total++;
        press(K_CLR);
        if (state_o !== 2'd0 || op_sign !== 4'd10 || entry_disp !== 16'h0000) begin bad++; $display("FAIL clr_done got state=%0d op=%0d disp=%h want 0 10 0000", state_o, op_sign, entry_disp); end total++;
    endtask

    task automatic test_reset_mid;
        int p0;
        press(4'd4); press(4'd2); press(K_ADD);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        if (state_o !== 2'd0 || num !== 12'h000 || op_sign !== 4'd10 || entry_disp !== 16'h0000) begin bad++; $display("FAIL async_rst got state=%0d num=%h op=%0d disp=%h want 0 000 10 0000", state_o, num, op_sign, entry_disp); end total++;
        @(negedge clk);
        rst_n = 1'b1;
        p0 = pulses;
        press(K_EQ); press(K_EQ);
        idle(2);
        if (pulses - p0 !== 0 || calc_valid !== 1'b0 || state_o !== 2'd0 || sub !== 12'h000) begin bad++; $display("FAIL rst_mid_eq got pulses=%0d calc=%b state=%0d sub=%h want 0 0 0 000", pulses - p0, calc_valid, state_o, sub); end total++;
    endtask

    initial begin
        test_reset;
        test_subtract;
        test_overflow;
        test_last_op;
        test_done_digit;
        test_ignored;
        test_empty_operands;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
